// File: rtl/batrider_input_cond.sv
// Batrider input conditioning: sync, debounce and coin pulse shaping.
// Optional autofire on button 1 is built when BATRIDER_AUTOFIRE_EN is defined.
module batrider_input_cond #(
    parameter int DEB_TICKS   = 4,
    parameter int COIN_FRAMES = 3,
    parameter int COIN_GAP    = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CEN,
    input  logic       VS,
    input  logic [1:0] AUTOFIRE,
    input  logic [9:0] JOYSTICK1_IN,
    input  logic [9:0] JOYSTICK2_IN,
    input  logic [3:0] START_IN,
    input  logic [3:0] COIN_IN,
    input  logic       SERVICE_IN,
    output logic [9:0] JOYSTICK1,
    output logic [9:0] JOYSTICK2,
    output logic [3:0] START_BUTTON,
    output logic [3:0] COIN_INPUT,
    output logic       SERVICE,
    output logic [3:0] COIN_BUSY
);

    localparam int NB = 29;
    localparam logic [3:0] DEB_T = 4'(DEB_TICKS);
    localparam logic [3:0] CF_T  = 4'(COIN_FRAMES);
    localparam logic [3:0] CG_T  = 4'(COIN_GAP);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_st_t;

    logic [NB-1:0] raw, s1, s2, deb;
    logic [3:0]    cnt [NB];
    logic          vs1, vs2, vs3, frame_tick;
    logic [3:0]    coin_q, press;

    assign raw = {SERVICE_IN, COIN_IN, START_IN, JOYSTICK2_IN, JOYSTICK1_IN};

    // two-flop synchronisers for all raw bits and VS, plus VS edge history
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1  <= '1;
            s2  <= '1;
            vs1 <= 1'b1;
            vs2 <= 1'b1;
            vs3 <= 1'b1;
        end else begin
            s1  <= raw;
            s2  <= s1;
            vs1 <= VS;
            vs2 <= vs1;
            vs3 <= vs2;
        end
    end

    assign frame_tick = vs2 & ~vs3;

    // per-bit debounce: flip after DEB_TICKS consecutive differing CEN samples
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            deb <= '1;
            for (int b = 0; b < NB; b++) cnt[b] <= 4'd0;
        end else if (CEN) begin
            for (int b = 0; b < NB; b++) begin
                if (s2[b] == deb[b]) begin
                    cnt[b] <= 4'd0;
                end else if (cnt[b] + 4'd1 == DEB_T) begin
                    deb[b] <= ~deb[b];
                    cnt[b] <= 4'd0;
                end else begin
                    cnt[b] <= cnt[b] + 4'd1;
                end
            end
        end
    end

    // previous debounced coin levels for press (falling edge) detection
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) coin_q <= '1;
        else       coin_q <= deb[27:24];
    end

    assign press = coin_q & ~deb[27:24];

    for (genvar i = 0; i < 4; i++) begin : g_coin
        coin_st_t   st, st_n;
        logic [3:0] fc, fc_n;
        logic [1:0] pend, pend_n;
        logic [2:0] sum;
        logic       deq;

        // coin FSM state, frame count and pending queue depth
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                st   <= IDLE;
                fc   <= 4'd0;
                pend <= 2'd0;
            end else begin
                st   <= st_n;
                fc   <= fc_n;
                pend <= pend_n;
            end
        end

        // next-state: start pulses from the queue, time pulse and gap in frames
        always_comb begin
            st_n = st;
            fc_n = fc;
            deq  = 1'b0;
            unique case (st)
                IDLE: begin
                    if (pend != 2'd0 || press[i]) begin
                        st_n = PULSE;
                        fc_n = 4'd0;
                        deq  = 1'b1;
                    end
                end
                PULSE: begin
                    if (frame_tick) begin
                        if (fc + 4'd1 == CF_T) begin
                            st_n = GAP;
                            fc_n = 4'd0;
                        end else begin
                            fc_n = fc + 4'd1;
                        end
                    end
                end
                GAP: begin
                    if (frame_tick) begin
                        if (fc + 4'd1 == CG_T) begin
                            st_n = IDLE;
                            fc_n = 4'd0;
                        end else begin
                            fc_n = fc + 4'd1;
                        end
                    end
                end
                default: st_n = IDLE;
            endcase
            sum    = {1'b0, pend} + {2'b0, press[i]} - {2'b0, deq};
            pend_n = sum[2] ? 2'd3 : sum[1:0];
        end

        assign COIN_INPUT[i] = (st != PULSE);
        assign COIN_BUSY[i]  = (st != IDLE) | (pend != 2'd0);
    end

    assign START_BUTTON = deb[23:20];
    assign SERVICE      = deb[28];

`ifdef BATRIDER_AUTOFIRE_EN
    logic [1:0] af_held, af_run, af_out, af_hi;
    logic [1:0] af_ph [2];

    assign af_held = AUTOFIRE & ~{deb[14], deb[4]};
    assign af_hi   = {af_ph[1][1], af_ph[0][1]};
    assign af_out  = ~(af_held & af_run & ~af_hi);

    // autofire phase: starts low on first frame after press, 2 frames per half
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            af_run <= 2'b00;
            for (int p = 0; p < 2; p++) af_ph[p] <= 2'd0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (!af_held[p]) begin
                    af_run[p] <= 1'b0;
                    af_ph[p]  <= 2'd0;
                end else if (frame_tick) begin
                    if (!af_run[p]) begin
                        af_run[p] <= 1'b1;
                        af_ph[p]  <= 2'd0;
                    end else begin
                        af_ph[p] <= af_ph[p] + 2'd1;
                    end
                end
            end
        end
    end

    assign JOYSTICK1 = {deb[9:5], af_out[0], deb[3:0]};
    assign JOYSTICK2 = {deb[19:15], af_out[1], deb[13:10]};
`else
    logic unused_autofire;
    assign unused_autofire = ^AUTOFIRE;
    assign JOYSTICK1 = deb[9:0];
    assign JOYSTICK2 = deb[19:10];
`endif

endmodule

// File: tb/tb_batrider_input_cond.sv
// Bench for batrider_input_cond: random and directed stimulus
// against a window-debounce / remaining-frames reference model.
module tb_batrider_input_cond;

    localparam int DEB = 4;
    localparam int CF  = 3;
    localparam int CG  = 3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CEN = 1'b0;
    logic       VS = 1'b0;
    logic [1:0] AUTOFIRE = 2'b00;
    logic [9:0] j1 = '1, j2 = '1;
    logic [3:0] st = '1, cn = '1;
    logic       sv = 1'b1;
    logic [9:0] JOYSTICK1, JOYSTICK2;
    logic [3:0] START_BUTTON, COIN_INPUT, COIN_BUSY;
    logic       SERVICE;

    batrider_input_cond #(
        .DEB_TICKS(DEB), .COIN_FRAMES(CF), .COIN_GAP(CG)
    ) dut (
        .CLK(CLK), .RESET(RESET), .CEN(CEN), .VS(VS),
        .AUTOFIRE(AUTOFIRE),
        .JOYSTICK1_IN(j1), .JOYSTICK2_IN(j2),
        .START_IN(st), .COIN_IN(cn), .SERVICE_IN(sv),
        .JOYSTICK1(JOYSTICK1), .JOYSTICK2(JOYSTICK2),
        .START_BUTTON(START_BUTTON), .COIN_INPUT(COIN_INPUT),
        .SERVICE(SERVICE), .COIN_BUSY(COIN_BUSY)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    logic [28:0] m_deb;
    logic [28:0] hist[$];
    int lo[4], gp[4], pd[4];
    logic [3:0] prev_coin;
    int falls[4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [28:0] raw_vec();
        return {sv, cn, st, j2, j1};
    endfunction

    function automatic void m_reset();
        m_deb = '1;
        hist.delete();
        for (int i = 0; i < 4; i++) begin
            lo[i] = 0; gp[i] = 0; pd[i] = 0;
        end
    endfunction

    function automatic void m_settle(int i);
        if (lo[i] == 0 && gp[i] == 0 && pd[i] > 0) begin
            pd[i]--;
            lo[i] = CF;
        end
    endfunction

    // a bit flips once the last DEB samples all disagree with it
    function automatic void m_cen(logic [28:0] s);
        logic [28:0] old;
        bit all_diff;
        old = m_deb;
        hist.push_back(s);
        if (hist.size() > DEB) void'(hist.pop_front());
        if (hist.size() == DEB) begin
            for (int b = 0; b < 29; b++) begin
                all_diff = 1;
                for (int k = 0; k < DEB; k++)
                    if (hist[k][b] == old[b]) all_diff = 0;
                if (all_diff) m_deb[b] = ~old[b];
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (old[24+i] && !m_deb[24+i]) begin
                pd[i] = (pd[i] < 3) ? pd[i] + 1 : 3;
                m_settle(i);
            end
        end
    endfunction

    function automatic void m_frame();
        for (int i = 0; i < 4; i++) begin
            if (lo[i] > 0) begin
                lo[i]--;
                if (lo[i] == 0) gp[i] = CG;
            end else if (gp[i] > 0) begin
                gp[i]--;
            end
            m_settle(i);
        end
    endfunction

    function automatic logic [3:0] m_coin();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (lo[i] == 0);
        return v;
    endfunction

    function automatic logic [3:0] m_busy();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (lo[i] | gp[i] | pd[i]) != 0;
        return v;
    endfunction

    task automatic compare_all();
        chk("joy1", 32'(JOYSTICK1), 32'(m_deb[9:0]));
        chk("joy2", 32'(JOYSTICK2), 32'(m_deb[19:10]));
        chk("start", 32'(START_BUTTON), 32'(m_deb[23:20]));
        chk("coin", 32'(COIN_INPUT), 32'(m_coin()));
        chk("service", 32'(SERVICE), 32'(m_deb[28]));
        chk("busy", 32'(COIN_BUSY), 32'(m_busy()));
        for (int i = 0; i < 4; i++)
            if (prev_coin[i] && !COIN_INPUT[i]) falls[i]++;
        prev_coin = COIN_INPUT;
    endtask

    // one time slot: optional CEN sample, optional frame, then compare
    task automatic slot(input bit cen_en, input bit vs_en);
        logic [28:0] s;
        s = raw_vec();
        repeat (4) @(negedge CLK);
        CEN = cen_en;
        @(negedge CLK);
        CEN = 1'b0;
        if (cen_en) m_cen(s);
        repeat (3) @(negedge CLK);
        VS = vs_en;
        repeat (5) @(negedge CLK);
        VS = 1'b0;
        if (vs_en) m_frame();
        repeat (4) @(negedge CLK);
        compare_all();
    endtask

    task automatic coin_press(input int i, input int n);
        repeat (n) begin
            cn[i] = 1'b0;
            repeat (DEB) slot(1, 0);
            cn[i] = 1'b1;
            repeat (DEB) slot(1, 0);
        end
    endtask

    initial begin
        m_reset();
        prev_coin = '1;
        for (int i = 0; i < 4; i++) falls[i] = 0;
        repeat (3) @(negedge CLK);
        chk("rst_coin", 32'(COIN_INPUT), 32'hF);
        chk("rst_busy", 32'(COIN_BUSY), 32'h0);
        chk("rst_joy1", 32'(JOYSTICK1), 32'h3FF);
        RESET = 1'b0;
        slot(1, 1);

        // debounce: three samples are not enough, four are
        j1[0] = 1'b0;
        repeat (DEB - 1) slot(1, 0);
        j1[0] = 1'b1;
        slot(1, 0);
        chk("deb_short", 32'(JOYSTICK1[0]), 32'd1);
        j1[0] = 1'b0;
        repeat (DEB) slot(1, 0);
        chk("deb_full", 32'(JOYSTICK1[0]), 32'd0);
        j1[0] = 1'b1;
        repeat (DEB) slot(1, 0);

        // single coin, then drain
        falls[0] = 0;
        coin_press(0, 1);
        repeat (10) slot(0, 1);
        chk("single_cnt", 32'(falls[0]), 32'd1);
        chk("single_idle", 32'(COIN_BUSY[0]), 32'd0);

        // burst of five presses within the first pulse: four pulses
        falls[1] = 0;
        coin_press(1, 5);
        repeat (40) slot(0, 1);
        chk("burst_cnt", 32'(falls[1]), 32'd4);

        // parallel coins
        cn[0] = 1'b0; cn[2] = 1'b0;
        repeat (DEB) slot(1, 0);
        chk("par_fall", 32'(COIN_INPUT & 4'b0101), 32'h0);
        cn[0] = 1'b1; cn[2] = 1'b1;
        repeat (DEB) slot(1, 0);
        repeat (10) slot(0, 1);

        // reset mid-pulse with coins pending
        coin_press(0, 3);
        chk("pre_rst_busy", 32'(COIN_BUSY[0]), 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("mid_rst_coin", 32'(COIN_INPUT), 32'hF);
        chk("mid_rst_busy", 32'(COIN_BUSY), 32'h0);
        m_reset();
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        falls[0] = 0;
        prev_coin = COIN_INPUT;
        repeat (12) slot(0, 1);
        chk("post_rst_cnt", 32'(falls[0]), 32'd0);

        // random phase
        for (int n = 0; n < 400; n++) begin
            logic [28:0] r;
            r = raw_vec();
            for (int b = 0; b < 29; b++)
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
            {sv, cn, st, j2, j1} = r;
            slot($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
